arith_interval_encoder: RTL and testbench

ARITH_INTERVAL_ENCODER -- requirements
Module: arith_interval_encoder

---
 rtl/arith_interval_encoder.sv | 234 +++++++++++++++++++++++
 tb/tb_arith_interval_encoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_interval_encoder.sv
`timescale 1ns/1ps
// Purpose : binary arithmetic-coder interval update, renormalisation and
//           termination (flush), emitting one code bit per strobe.
// Latency : 3 cycles minimum per request (CALC, RENORM, DONE), plus one cycle
//           per shifted/underflow step and per pending bit emitted.
// Backpressure: ready_out is high only in IDLE; bit_valid_out has no
//           backpressure and must be consumed whenever it strobes.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   valid_in / ready_out      request handshake; accepted on valid_in && ready_out
//   flush_in                  request is a termination rather than a symbol
//   prob_lower_in/upper_in    cumulative counts of the symbol, shift_in = log2(total)
//   bit_valid_out / bit_out   emitted code bit strobe and value
//   work_lower_out/upper_out  current interval bounds (registered)
//   pending_out               outstanding underflow bits
//   done_out                  one-cycle pulse when a request completes
//   error_out                 sticky illegal-probability / pending-overflow flag
module arith_interval_encoder #(
    parameter int PREC   = 16,
    parameter int PROB_W = 16,
    parameter int PEND_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    output logic                        ready_out,
    input  logic                        flush_in,
    input  logic [PROB_W-1:0]           prob_lower_in,
    input  logic [PROB_W-1:0]           prob_upper_in,
    input  logic [$clog2(PROB_W+1)-1:0] shift_in,
    output logic                        bit_valid_out,
    output logic                        bit_out,
    output logic [PREC-1:0]             work_lower_out,
    output logic [PREC-1:0]             work_upper_out,
    output logic [PEND_W-1:0]           pending_out,
    output logic                        done_out,
    output logic                        error_out
);

    localparam int SHIFT_W = $clog2(PROB_W+1);
    localparam int PW      = PREC + 1 + PROB_W;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [PREC-1:0]   PREC_ONE = PREC'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_RENORM,
        S_FOLLOW,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PREC-1:0]     low_q, low_d;
    logic [PREC-1:0]     high_q, high_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                err_q, err_d;
    logic                flush_q, flush_d;
    logic [PROB_W-1:0]   plo_q, plo_d;
    logic [PROB_W-1:0]   pup_q, pup_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic                last_q, last_d;
    logic                bvld_q, bvld_d;
    logic                bit_q, bit_d;

    // Interval arithmetic for the captured symbol.
    logic [PREC:0]       range_w;
    logic [PW-1:0]       prod_hi_w, prod_lo_w;
    logic [PREC-1:0]     scl_hi_w, scl_lo_w;
    logic [PREC-1:0]     new_hi_w, new_lo_w;
    logic [PROB_W:0]     total_w;
    logic                up_too_big_w, illegal_w;
    logic                same_msb_w, underflow_w, pend_full_w;

    always_comb begin
        range_w   = {1'b0, high_q} - {1'b0, low_q} + {{PREC{1'b0}}, 1'b1};
        // Full-width products; truncation to PREC happens only after the shift.
        prod_hi_w = PW'(range_w) * PW'(pup_q);
        prod_lo_w = PW'(range_w) * PW'(plo_q);
        scl_hi_w  = PREC'(prod_hi_w >> shift_q);
        scl_lo_w  = PREC'(prod_lo_w >> shift_q);
        new_hi_w  = low_q + scl_hi_w - PREC_ONE;
        new_lo_w  = low_q + scl_lo_w;

        // For shifts wider than PROB_W the upper count can never exceed the total.
        total_w      = (PROB_W+1)'(1) << shift_q;
        up_too_big_w = (shift_q <= SHIFT_W'(PROB_W)) && ({1'b0, pup_q} > total_w);
        illegal_w    = (plo_q >= pup_q) || (shift_q == '0) || up_too_big_w;

        same_msb_w  = (low_q[PREC-1] == high_q[PREC-1]);
        underflow_w = (low_q[PREC-1:PREC-2] == 2'b01) && (high_q[PREC-1:PREC-2] == 2'b10);
        pend_full_w = &pend_q;
    end

    always_comb begin
        state_d = state_q;
        low_d   = low_q;
        high_d  = high_q;
        pend_d  = pend_q;
        err_d   = err_q;
        flush_d = flush_q;
        plo_d   = plo_q;
        pup_d   = pup_q;
        shift_d = shift_q;
        last_d  = last_q;
        bvld_d  = 1'b0;
        bit_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    flush_d = flush_in;
                    plo_d   = prob_lower_in;
                    pup_d   = prob_upper_in;
                    shift_d = shift_in;
                    state_d = S_CALC;
                end
            end

            S_CALC: begin
                if (flush_q) begin
                    // Termination: one more pending step, then low's second bit
                    // followed by the pending bits inverted.
                    if (pend_full_w) begin
                        err_d = 1'b1;
                    end else begin
                        pend_d = pend_q + PEND_ONE;
                    end
                    bvld_d  = 1'b1;
                    bit_d   = low_q[PREC-2];
                    last_d  = low_q[PREC-2];
                    state_d = S_FOLLOW;
                end else if (illegal_w) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    low_d   = new_lo_w;
                    high_d  = new_hi_w;
                    state_d = S_RENORM;
                end
            end

            S_RENORM: begin
                if (same_msb_w) begin
                    bvld_d = 1'b1;
                    bit_d  = low_q[PREC-1];
                    last_d = low_q[PREC-1];
                    low_d  = {low_q[PREC-2:0], 1'b0};
                    high_d = {high_q[PREC-2:0], 1'b1};
                    if (pend_q != '0) begin
                        state_d = S_FOLLOW;
                    end
                end else if (underflow_w) begin
                    // Straddling the midpoint: expand around the centre and
                    // defer the decision as a pending bit.
                    if (pend_full_w) begin
                        err_d = 1'b1;
                    end else begin
                        pend_d = pend_q + PEND_ONE;
                    end
                    low_d  = {~low_q[PREC-2], low_q[PREC-3:0], 1'b0};
                    high_d = {~high_q[PREC-2], high_q[PREC-3:0], 1'b1};
                end else begin
                    state_d = S_DONE;
                end
            end

            S_FOLLOW: begin
                bvld_d = 1'b1;
                bit_d  = ~last_q;
                pend_d = pend_q - PEND_ONE;
                if (pend_q <= PEND_ONE) begin
                    pend_d = '0;
                    if (flush_q) begin
                        low_d   = '0;
                        high_d  = '1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RENORM;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            low_q   <= '0;
            high_q  <= '1;
            pend_q  <= '0;
            err_q   <= 1'b0;
            flush_q <= 1'b0;
            plo_q   <= '0;
            pup_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            bvld_q  <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
            high_q  <= high_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            flush_q <= flush_d;
            plo_q   <= plo_d;
            pup_q   <= pup_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            bvld_q  <= bvld_d;
            bit_q   <= bit_d;
        end
    end

    assign ready_out      = (state_q == S_IDLE);
    assign done_out       = (state_q == S_DONE);
    assign bit_valid_out  = bvld_q;
    assign bit_out        = bit_q;
    assign work_lower_out = low_q;
    assign work_upper_out = high_q;
    assign pending_out    = pend_q;
    assign error_out      = err_q;

endmodule

// File: tb/tb_arith_interval_encoder.sv
`timescale 1ns/1ps
// Purpose : self-checking bench for arith_interval_encoder against an
//           interval-arithmetic reference model plus fixed known-answer cases.
// Latency/backpressure: requests are issued one at a time after ready_out.
module tb_arith_interval_encoder;

    localparam int PREC   = 16;
    localparam int PROB_W = 16;
    localparam int PEND_W = 16;
    localparam int SW     = $clog2(PROB_W+1);

    localparam longint MAXV = (64'd1 << PREC) - 1;
    localparam longint HALF = 64'd1 << (PREC-1);
    localparam longint QTR  = 64'd1 << (PREC-2);
    localparam longint PMAX = (64'd1 << PEND_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid_in = 1'b0;
    logic              flush_in = 1'b0;
    logic [PROB_W-1:0] plo = '0;
    logic [PROB_W-1:0] pup = '0;
    logic [SW-1:0]     sh  = '0;
    logic              ready_out, bit_valid_out, bit_out, done_out, error_out;
    logic [PREC-1:0]   work_lower_out, work_upper_out;
    logic [PEND_W-1:0] pending_out;

    arith_interval_encoder #(.PREC(PREC), .PROB_W(PROB_W), .PEND_W(PEND_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .flush_in       (flush_in),
        .prob_lower_in  (plo),
        .prob_upper_in  (pup),
        .shift_in       (sh),
        .bit_valid_out  (bit_valid_out),
        .bit_out        (bit_out),
        .work_lower_out (work_lower_out),
        .work_upper_out (work_upper_out),
        .pending_out    (pending_out),
        .done_out       (done_out),
        .error_out      (error_out)
    );

    always #5 clk = ~clk;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    int     done_cnt = 0;
    bit     got_q[$];
    longint got_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bit_valid_out) begin
            got_q.push_back(bit_out);
            got_cyc.push_back(cyc);
        end
        if (done_out) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: interval arithmetic on plain integers.
    longint m_low, m_high, m_pend;
    bit     m_err;
    bit     exp_q[$];

    task automatic model_reset();
        m_low  = 0;
        m_high = MAXV;
        m_pend = 0;
        m_err  = 0;
    endtask

    task automatic model_step(input bit fl, input longint lo, input longint up, input int s);
        longint rng, lo_new, hi_new;
        bit     b;
        bit     go;
        exp_q.delete();
        if (fl) begin
            if (m_pend == PMAX) m_err = 1; else m_pend++;
            b = ((m_low % HALF) >= QTR);
            exp_q.push_back(b);
            repeat (m_pend) exp_q.push_back(!b);
            m_low  = 0;
            m_high = MAXV;
            m_pend = 0;
            return;
        end
        if (lo >= up || s == 0 || up > (64'd1 << s)) begin
            m_err = 1;
            return;
        end
        rng    = m_high - m_low + 1;
        hi_new = (m_low + ((rng * up) >> s) - 1) & MAXV;
        lo_new = (m_low + ((rng * lo) >> s)) & MAXV;
        m_low  = lo_new;
        m_high = hi_new;
        go = 1;
        while (go) begin
            if ((m_low >= HALF) == (m_high >= HALF)) begin
                b = (m_low >= HALF);
                exp_q.push_back(b);
                repeat (m_pend) exp_q.push_back(!b);
                m_pend = 0;
                m_low  = (2 * m_low) & MAXV;
                m_high = (2 * m_high + 1) & MAXV;
            end else if (m_low >= QTR && m_low < HALF && m_high >= HALF && m_high < HALF + QTR) begin
                if (m_pend == PMAX) m_err = 1; else m_pend++;
                m_low  = 2 * (m_low - QTR);
                m_high = 2 * (m_high - QTR) + 1;
            end else begin
                go = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_low"},   work_lower_out, 0);
        chk({tag, "_high"},  work_upper_out, MAXV);
        chk({tag, "_pend"},  pending_out, 0);
        chk({tag, "_ready"}, ready_out, 1);
        chk({tag, "_err"},   error_out, 0);
        chk({tag, "_bvld"},  bit_valid_out, 0);
        chk({tag, "_done"},  done_out, 0);
    endtask

    // Leaves the caller at the first negedge after acceptance (CALC cycle).
    task automatic start_req(input bit fl, input longint lo, input longint up, input int s);
        int n = 0;
        @(negedge clk);
        while (!ready_out && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!ready_out) chk("ready_timeout", 0, 1);
        got_q.delete();
        got_cyc.delete();
        done_cnt = 0;
        valid_in = 1'b1;
        flush_in = fl;
        plo = PROB_W'(lo);
        pup = PROB_W'(up);
        sh  = SW'(s);
        @(negedge clk);
        valid_in = 1'b0;
        chk("ready_busy", ready_out, 0);
    endtask

    task automatic do_req(input string tag, input bit fl, input longint lo, input longint up,
                          input int s, output int lat);
        model_step(fl, lo, up, s);
        start_req(fl, lo, up, s);
        lat = 1;
        while (!done_out && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        if (!done_out) chk({tag, "_done_timeout"}, 0, 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done_out, 0);
        chk({tag, "_nbits"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_bit%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_low"},  work_lower_out, m_low);
        chk({tag, "_high"}, work_upper_out, m_high);
        chk({tag, "_pend"}, pending_out, m_pend);
        chk({tag, "_err"},  error_out, m_err);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int n;
        do_reset();
        check_reset_vals("reset");

        // Half-interval symbol: one 0 bit, four cycles to done.
        do_req("half", 0, 0, 16'h8000, 16, lat);
        chk("half_lat", lat, 4);
        chk("half_nb", got_q.size(), 1);
        if (got_q.size() >= 1) chk("half_b0", got_q[0], 0);
        chk("half_hi", work_upper_out, 16'hFFFF);

        // Middle symbol: underflow only, then half symbol resolves it.
        do_reset();
        do_req("mid", 0, 16'h4000, 16'hC000, 16, lat);
        chk("mid_nb", got_q.size(), 0);
        chk("mid_pend", pending_out, 1);
        chk("mid_lo", work_lower_out, 0);
        do_req("fol", 0, 0, 16'h8000, 16, lat);
        chk("fol_nb", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            chk("fol_b0", got_q[0], 0);
            chk("fol_b1", got_q[1], 1);
            chk("fol_consec", got_cyc[1] - got_cyc[0], 1);
        end
        chk("fol_pend", pending_out, 0);

        // Flush after an underflow: 0,1,1 then reset bounds.
        do_reset();
        do_req("mid2", 0, 16'h4000, 16'hC000, 16, lat);
        do_req("flush", 1, 0, 0, 16, lat);
        chk("flush_nb", got_q.size(), 3);
        if (got_q.size() >= 3) begin
            chk("flush_b0", got_q[0], 0);
            chk("flush_b1", got_q[1], 1);
            chk("flush_b2", got_q[2], 1);
        end
        chk("flush_lo", work_lower_out, 0);
        chk("flush_hi", work_upper_out, 16'hFFFF);
        chk("flush_pend", pending_out, 0);

        // Randomised symbol/flush stream against the model.
        do_reset();
        for (int k = 0; k < 60; k++) begin
            int     s;
            longint tot, up, lo;
            bit     fl;
            fl  = ($urandom_range(0, 7) == 0);
            s   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 16;
            tot = 64'd1 << s;
            up  = (tot > 65535) ? 65535 : tot;
            lo  = $urandom_range(0, int'(up) - 1);
            up  = $urandom_range(int'(lo) + 1, int'(up));
            if ($urandom_range(0, 15) == 0) up = lo;
            do_req($sformatf("rnd%0d", k), fl, lo, up, s, lat);
        end

        // Illegal probabilities.
        do_reset();
        do_req("ill_eq", 0, 16'h1000, 16'h1000, 16, lat);
        chk("ill_eq_err", error_out, 1);
        chk("ill_eq_lo", work_lower_out, 0);
        chk("ill_eq_hi", work_upper_out, 16'hFFFF);
        chk("ill_eq_done", done_cnt, 1);
        do_req("sticky", 0, 0, 16'h8000, 16, lat);
        chk("sticky_err", error_out, 1);
        do_reset();
        do_req("ill_sh0", 0, 0, 1, 0, lat);
        chk("ill_sh0_err", error_out, 1);
        do_reset();
        do_req("ill_big", 0, 0, 16'h9000, 15, lat);
        chk("ill_big_err", error_out, 1);

        // Reset while following pending bits of a flush.
        do_reset();
        for (int k = 0; k < 3; k++) do_req("acc", 0, 16'h4000, 16'hC000, 16, lat);
        chk("acc_pend", pending_out, 3);
        start_req(1, 0, 0, 16);
        n = 0;
        while (!bit_valid_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rstf_first_bit", bit_valid_out, 1);
        rst = 1'b1;
        @(posedge clk);
        got_q.delete();
        done_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_vals("rstf");
        repeat (10) @(negedge clk);
        chk("rstf_bits", got_q.size(), 0);
        chk("rstf_done", done_cnt, 0);
        chk("rstf_pend", pending_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
